// File: rtl/alu_seq_arbiter_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer and its arbiter.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes presented to the 4-bit arithmeticUnit.
  localparam logic [1:0] AU_OP_NONE = 2'b00;
  localparam logic [1:0] AU_OP_ADD  = 2'b01;
  localparam logic [1:0] AU_OP_SUB  = 2'b10;

  // Per-requester operation select on req_op.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [1:0] oneHot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_seq_arbiter_if.sv
// Requester-side bus of alu_seq_arbiter: two request channels in, one shared response out.
interface alu_seq_arbiter_if #(
  parameter int WIDTH = 8
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // A requester holds valid and its operands stable until accepted; ready may depend on valid.
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_op;
  logic [1:0]         req_cin;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_y;
  logic               rsp_carry;
  logic               rsp_overflow;

  modport master (
    output req_valid, req_op, req_cin, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_cin, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_overflow
  );

endinterface

// File: rtl/alu_seq_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the pointer only moves when the owner retires its response.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] reqValid,
  input  logic       ptrLoad,
  input  logic       ptrNext,
  output logic [1:0] grant
);

  logic rrPtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= 1'b0;
    end else if (ptrLoad) begin
      rrPtr <= ptrNext;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (reqValid[rrPtr]) begin
      grant = oneHot2(rrPtr);
    end else if (reqValid[~rrPtr]) begin
      grant = oneHot2(~rrPtr);
    end
  end

endmodule

// File: rtl/alu_seq_arbiter.sv
// Shares one 4-bit arithmeticUnit between two requesters, running WIDTH-bit add/sub one nibble per cycle.
module alu_seq_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_seq_arbiter_if.slave    bus,
  output logic                busy,
  output logic [1:0]          au_opCode,
  output logic [3:0]          au_A,
  output logic [3:0]          au_B,
  output logic                au_CarryIN,
  input  logic [3:0]          au_add_Y,
  input  logic                au_CarryOUT,
  input  logic                au_overflow,
  output state_t              dbgState
);

  // WIDTH is expected to be a multiple of 4 and at least 4.
  localparam int NPASS = WIDTH / 4;
  localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  state_t            state;
  state_t            nextState;
  logic [1:0]        grant;
  logic              accept;
  logic              rspDone;
  logic              ownerReg;
  logic [WIDTH-1:0]  aReg;
  logic [WIDTH-1:0]  bReg;
  logic              opReg;
  logic              cinReg;
  logic [PW-1:0]     passCnt;
  logic              carryReg;
  logic [WIDTH-1:0]  resY;
  logic              rspCarryReg;
  logic              rspOvfReg;
  logic              lastPass;
  logic [3:0]        aNib;
  logic [3:0]        bNib;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqValid (bus.req_valid),
    .ptrLoad  (rspDone),
    .ptrNext  (~ownerReg),
    .grant    (grant)
  );

  assign lastPass = (passCnt == PW'(NPASS - 1));
  assign aNib     = aReg[{passCnt, 2'b00} +: 4];
  assign bNib     = bReg[{passCnt, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    busy          = 1'b0;
    accept        = 1'b0;
    rspDone       = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    au_opCode     = AU_OP_NONE;
    au_A          = 4'h0;
    au_B          = 4'h0;
    au_CarryIN    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so req_ready drops the instant reset asserts.
        bus.req_ready = rst_n ? grant : 2'b00;
        accept        = rst_n && (grant != 2'b00);
        if (accept) begin
          nextState = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        au_opCode = AU_OP_ADD;
        au_A      = aNib;
        // Subtract is A + ~B + 1 through the add path.
        au_B      = (opReg == OP_SUB) ? ~bNib : bNib;
        if (passCnt == '0) begin
          au_CarryIN = (opReg == OP_SUB) ? 1'b1 : cinReg;
        end else begin
          au_CarryIN = carryReg;
        end
        if (lastPass) begin
          nextState = RESP;
        end
      end
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = oneHot2(ownerReg);
        rspDone       = bus.rsp_ready[ownerReg];
        if (rspDone) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ownerReg    <= 1'b0;
      aReg        <= '0;
      bReg        <= '0;
      opReg       <= OP_ADD;
      cinReg      <= 1'b0;
      passCnt     <= '0;
      carryReg    <= 1'b0;
      resY        <= '0;
      rspCarryReg <= 1'b0;
      rspOvfReg   <= 1'b0;
    end else begin
      if (accept) begin
        ownerReg <= grant[1];
        aReg     <= grant[1] ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        bReg     <= grant[1] ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        opReg    <= grant[1] ? bus.req_op[1]  : bus.req_op[0];
        cinReg   <= grant[1] ? bus.req_cin[1] : bus.req_cin[0];
        passCnt  <= '0;
      end
      if (state == RUN) begin
        resY[{passCnt, 2'b00} +: 4] <= au_add_Y;
        carryReg                    <= au_CarryOUT;
        passCnt                     <= passCnt + PW'(1);
        // Only the top nibble's carry and overflow describe the full-width result.
        if (lastPass) begin
          rspCarryReg <= au_CarryOUT;
          rspOvfReg   <= au_overflow;
        end
      end
    end
  end

  assign bus.rsp_y        = resY;
  assign bus.rsp_carry    = rspCarryReg;
  assign bus.rsp_overflow = rspOvfReg;
  assign dbgState         = state;

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one 4-bit arithmeticUnit between two requesters.
- Performs WIDTH-bit add/subtract by driving the arithmeticUnit one nibble per cycle, LSB first, chaining the carry.
- Returns the WIDTH-bit result, final carry and signed overflow to the requester that won arbitration.
- Sits between the operand sources and the arithmeticUnit instance; it is the only driver of that instance's inputs.

Parameters:
- WIDTH, 8: operand/result width; must be a multiple of 4 and at least 4.
- NPASS, WIDTH/4: derived nibble pass count; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted when valid&ready at a rising edge.
- req_op  in  2  per requester: 0 = add, 1 = subtract.
- req_cin  in  2  per requester carry-in; used for add only.
- req_a  in  2*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  packed operand B, same packing as req_a.
- rsp_valid  out  2  one-hot response valid to the owning requester.
- rsp_ready  in  2  response consumed; only the owner's bit is observed.
- rsp_y  out  WIDTH  result.
- rsp_carry  out  1  final carry out; for subtract, 1 = no borrow.
- rsp_overflow  out  1  signed overflow of the full-width operation.
- busy  out  1  high in every state except IDLE.
- au_opCode  out  2  to arithmeticUnit: 01 during RUN, 00 otherwise.
- au_A  out  4  current nibble of A.
- au_B  out  4  current nibble of B, inverted for subtract.
- au_CarryIN  out  1  chained carry.
- au_add_Y  in  4  from arithmeticUnit.
- au_CarryOUT  in  1  from arithmeticUnit.
- au_overflow  in  1  from arithmeticUnit.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, rr_ptr = 0, pass counter = 0.
  - All outputs 0: rsp_y, rsp_carry, rsp_overflow, rsp_valid, req_ready, busy, and all au_* outputs.
  - Any in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - grant = rr_ptr's requester if its req_valid is high, else the other requester if its req_valid is high.
  - req_ready = one-hot grant (combinational); all zero if no request.
  - On handshake: latch A, B, op, cin and owner; clear the pass counter; go to RUN.
  - au_opCode = 00, au_A = au_B = 0, au_CarryIN = 0.
- RUN, pass k = 0 .. NPASS-1, one cycle each:
  - au_opCode = 01.
  - au_A = A[4k+3:4k].
  - au_B = B nibble k for add; ~B nibble k for subtract.
  - au_CarryIN on pass 0 = cin for add, 1 for subtract; on later passes = carry registered from the previous pass.
  - Each edge: store au_add_Y into result nibble k and register au_CarryOUT.
  - On the last pass: capture au_CarryOUT into rsp_carry and au_overflow into rsp_overflow, then go to RESP.
  - The sub_Y output of arithmeticUnit is unused; subtraction is done as two's complement through the add path.
- RESP:
  - rsp_valid[owner] = 1; rsp_y, rsp_carry and rsp_overflow are held stable.
  - On rsp_ready[owner]: go to IDLE and set rr_ptr = ~owner.
  - rsp_ready of the non-owner is ignored.
- Latency: handshake at edge N gives rsp_valid high after edge N+NPASS (N+2 for WIDTH=8). Minimum period between accepted requests is NPASS+1 cycles.
- req_ready is 0 outside IDLE.
- A requester must hold req_valid and its operands stable until accepted. Withdrawal before acceptance is allowed; no request is then granted.
- Results wrap modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg:
  - state encoding IDLE/RUN/RESP.
  - opcode constants AU_OP_NONE = 2'b00, AU_OP_ADD = 2'b01, AU_OP_SUB = 2'b10.
  - request op constants OP_ADD = 0, OP_SUB = 1.
- One natural sub-module, rr_arb2: a two-requester round-robin grant with a pointer-update input.
- The FSM and nibble datapath stay in alu_seq_arbiter.

Test Plan:
- Add with overflow: req0 add, A=0x47, B=0x39, cin=0.
  - au_A sequence 7 then 4; rsp_valid[0] two edges after accept.
  - Expect y=0x80, carry=0, overflow=1.
- Subtract: req1 sub, A=0x06, B=0x02.
  - au_B sequence 0xD then 0xF; au_CarryIN 1 on pass 0.
  - Expect y=0x04, carry=1, overflow=0.
- Carry ripple with carry-in: req0 add, A=0xFF, B=0x01, cin=1.
  - Expect y=0x01, carry=1, overflow=0; au_CarryIN=1 on both passes.
- Arbitration fairness: both requesters valid continuously, rr_ptr=0 after reset.
  - Grants alternate 0,1,0,1; each response is routed only to its owner; req_ready is never high for both bits.
- Backpressure: hold rsp_ready low for 5 cycles in RESP.
  - rsp_valid and rsp_y stay stable, busy=1, req_ready=0.
  - Raising rsp_ready[non-owner] has no effect.
- Reset mid-operation: drop rst_n during the RUN pass 1 cycle.
  - Outputs are 0 immediately, without waiting for an edge.
  - After release: IDLE, no stale rsp_valid; the next request completes correctly.
